// File: rtl/fir_pkg.sv
// Shared FIR widths, sample types and the clipping function used by both the
// filter and its output stage so they saturate identically.
package fir_pkg;

  localparam int FIR_IN_W  = 32;
  localparam int FIR_OUT_W = 16;

  typedef logic signed [FIR_OUT_W-1:0] fir_sample_t;
  typedef logic signed [FIR_IN_W-1:0]  fir_acc_t;
  typedef logic signed [FIR_IN_W:0]    fir_wide_t;

  typedef struct packed {
    logic        clip;
    fir_sample_t val;
  } fir_sat_t;

  localparam fir_wide_t SAT_MAX = fir_wide_t'((2 ** (FIR_OUT_W - 1)) - 1);
  localparam fir_wide_t SAT_MIN = -fir_wide_t'(2 ** (FIR_OUT_W - 1));

  function automatic fir_sat_t saturate(input fir_wide_t v);
    fir_sat_t res;
    res.clip = 1'b0;
    res.val  = v[FIR_OUT_W-1:0];
    if (v > SAT_MAX) begin
      res.clip = 1'b1;
      res.val  = {1'b0, {(FIR_OUT_W-1){1'b1}}};
    end else if (v < SAT_MIN) begin
      res.clip = 1'b1;
      res.val  = {1'b1, {(FIR_OUT_W-1){1'b0}}};
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous first-word-fall-through FIFO; a write into a full FIFO is
// accepted when a read happens in the same cycle.
module fir_out_fifo
  import fir_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  output logic [W-1:0]  rd_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic         rd_ok, wr_ok;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (level_o == '0);
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign rd_ok   = rd_en_i && !empty_o;
  assign wr_ok   = wr_en_i && (!full_o || rd_ok);

  // Head is forced to zero when empty so the stream data reads 0 after reset.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(rd_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/fir_out_stage.sv
// FIR output stage: decimate, round-shift, saturate, buffer in a FWFT FIFO and
// stream out. Define FIR_OUT_STATS_EN to add the sat_count statistics port.
module fir_out_stage
  import fir_pkg::*;
#(
  parameter int IN_W       = FIR_IN_W,
  parameter int OUT_W      = FIR_OUT_W,
  parameter int SHIFT      = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic signed [IN_W-1:0]        y_in,
  input  logic [3:0]                    dec_factor,
  output logic signed [OUT_W-1:0]       m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          sat_flag,
  output logic                          ovf_flag,
  input  logic                          flag_clr
`ifdef FIR_OUT_STATS_EN
  , output logic [15:0]                 sat_count
`endif
);

  localparam logic signed [IN_W:0] RND = (IN_W+1)'(1) << (SHIFT-1);

  logic [3:0] dec_cnt_q, dec_cnt_d, dec_eff_q, dec_eff_d, dec_req;
  logic       keep;

  // A zero factor behaves as one; the new factor only loads at a group wrap.
  assign dec_req = (dec_factor == 4'd0) ? 4'd1 : dec_factor;
  assign keep    = ena && (dec_cnt_q == dec_eff_q - 4'd1);

  always_comb begin
    dec_cnt_d = dec_cnt_q;
    dec_eff_d = dec_eff_q;
    if (keep) begin
      dec_cnt_d = 4'd0;
      dec_eff_d = dec_req;
    end else if (ena) begin
      dec_cnt_d = dec_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_cnt_q <= 4'd0;
      dec_eff_q <= dec_req;
    end else begin
      dec_cnt_q <= dec_cnt_d;
      dec_eff_q <= dec_eff_d;
    end
  end

  // Stage 1: one extra bit so rounding the max positive input cannot wrap.
  logic signed [IN_W:0] y_ext, y_rnd, s1_r_q, s1_r_d;
  logic                 s1_vld_q;

  assign y_ext  = {y_in[IN_W-1], y_in};
  assign y_rnd  = y_ext + RND;
  assign s1_r_d = y_rnd >>> SHIFT;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_r_q   <= '0;
    end else begin
      s1_vld_q <= keep;
      s1_r_q   <= s1_r_d;
    end
  end

  // Stage 2: saturation feeds the FIFO write directly.
  fir_sat_t sat;
  logic     fifo_full, fifo_empty, sat_set, ovf_set;

  assign sat = saturate(s1_r_q);

  fir_out_fifo #(.W(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (s1_vld_q),
    .wr_data_i (sat.val),
    .rd_en_i   (m_ready),
    .rd_data_o (m_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  assign m_valid = !fifo_empty;
  assign sat_set = s1_vld_q && sat.clip;
  assign ovf_set = s1_vld_q && fifo_full && !(m_valid && m_ready);

  logic sat_flag_q, sat_flag_d, ovf_flag_q, ovf_flag_d;

  // Clear wins over a same-cycle set; that set event is lost.
  always_comb begin
    sat_flag_d = sat_flag_q | sat_set;
    ovf_flag_d = ovf_flag_q | ovf_set;
    if (flag_clr) begin
      sat_flag_d = 1'b0;
      ovf_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_flag_q <= 1'b0;
      ovf_flag_q <= 1'b0;
    end else begin
      sat_flag_q <= sat_flag_d;
      ovf_flag_q <= ovf_flag_d;
    end
  end

  assign sat_flag = sat_flag_q;
  assign ovf_flag = ovf_flag_q;

`ifdef FIR_OUT_STATS_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (flag_clr)                            sat_cnt_d = 16'd0;
    else if (sat_set && sat_cnt_q != 16'hFFFF) sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sat_cnt_q <= 16'd0;
    else        sat_cnt_q <= sat_cnt_d;
  end

  assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_fir_out_stage.sv
// Scoreboard bench for fir_out_stage: expected samples are queued as stimulus
// is driven and popped whenever the stream performs a transfer.
module tb_fir_out_stage;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               ena = 1'b0;
  logic signed [31:0] y_in = '0;
  logic [3:0]         dec_factor = 4'd1;
  logic signed [15:0] m_data;
  logic               m_valid;
  logic               m_ready = 1'b1;
  logic [2:0]         fifo_level;
  logic               sat_flag, ovf_flag;
  logic               flag_clr = 1'b0;
`ifdef FIR_OUT_STATS_EN
  logic [15:0]        sat_count;
`endif

  int checks = 0;
  int errors = 0;
  logic signed [15:0] exp_q[$];

  fir_out_stage #(.IN_W(32), .OUT_W(16), .SHIFT(7), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .y_in       (y_in),
    .dec_factor (dec_factor),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .fifo_level (fifo_level),
    .sat_flag   (sat_flag),
    .ovf_flag   (ovf_flag),
    .flag_clr   (flag_clr)
`ifdef FIR_OUT_STATS_EN
    , .sat_count (sat_count)
`endif
  );

  always #5 clk = ~clk;

  // Inputs are final when tick is entered, so a transfer at the coming edge
  // is decided here; outputs are then sampled on the falling edge.
  task automatic tick();
    logic signed [15:0] e;
    if (rst_n && m_valid && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra got %0d exp none", m_data);
      end else begin
        e = exp_q.pop_front();
        if (m_data !== e) begin
          errors++;
          $display("FAIL sb_data got %0d exp %0d", m_data, e);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    ena   = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic drain(input int budget);
    m_ready = 1'b1;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d left exp 0", exp_q.size());
    end
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_reset();
    checks++;
    if (m_valid !== 1'b0 || m_data !== 16'sd0 || fifo_level !== 3'd0 ||
        sat_flag !== 1'b0 || ovf_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got v=%b d=%0d l=%0d s=%b o=%b exp all 0",
               m_valid, m_data, fifo_level, sat_flag, ovf_flag);
    end
  endtask

  task automatic test_rounding();
    int                 ys[4]   = '{1000, -1000, 64, 63};
    logic signed [15:0] exps[4] = '{16'sd8, -16'sd8, 16'sd1, 16'sd0};
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ena  = 1'b1;
      y_in = ys[i];
      exp_q.push_back(exps[i]);
      tick();
      ena = 1'b0;
      checks++;
      if (m_valid !== 1'b0) begin
        errors++;
        $display("FAIL round_early y=%0d got valid %b exp 0", ys[i], m_valid);
      end
      tick();
      checks++;
      if (m_valid !== 1'b1 || m_data !== exps[i]) begin
        errors++;
        $display("FAIL round_lat2 y=%0d got v=%b d=%0d exp v=1 d=%0d",
                 ys[i], m_valid, m_data, exps[i]);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    checks++;
    if (sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL sat_pre got %b exp 0", sat_flag);
    end
    ena  = 1'b1;
    y_in = 32'h7FFF_FFFF;
    exp_q.push_back(16'sd32767);
    tick();
    ena = 1'b0;
    tick();
    checks++;
    if (m_data !== 16'sd32767 || sat_flag !== 1'b1) begin
      errors++;
      $display("FAIL sat_pos got d=%0d s=%b exp d=32767 s=1", m_data, sat_flag);
    end
`ifdef FIR_OUT_STATS_EN
    checks++;
    if (sat_count !== 16'd1) begin
      errors++;
      $display("FAIL sat_count got %0d exp 1", sat_count);
    end
`endif
    ena  = 1'b1;
    y_in = 32'h8000_0000;
    exp_q.push_back(-16'sd32768);
    tick();
    ena = 1'b0;
    drain(20);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    checks++;
    if (sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL sat_clr got %b exp 0", sat_flag);
    end
`ifdef FIR_OUT_STATS_EN
    checks++;
    if (sat_count !== 16'd0) begin
      errors++;
      $display("FAIL sat_count_clr got %0d exp 0", sat_count);
    end
`endif
  endtask

  task automatic test_decimation();
    dec_factor = 4'd3;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      ena  = 1'b1;
      y_in = k * 128;
      if (k % 3 == 0) exp_q.push_back(16'(k));
      tick();
    end
    ena = 1'b0;
    drain(20);
    checks++;
    if (fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL dec3_level got %0d exp 0", fifo_level);
    end

    dec_factor = 4'd0;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      ena  = 1'b1;
      y_in = k * 128;
      exp_q.push_back(16'(k));
      tick();
    end
    ena = 1'b0;
    drain(20);

    // Factor changes to 2 after the first sample of a 3-group.
    dec_factor = 4'd3;
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      ena  = 1'b1;
      y_in = k * 128;
      if (k == 3 || k == 5 || k == 7) exp_q.push_back(16'(k));
      tick();
      dec_factor = 4'd2;
    end
    ena = 1'b0;
    drain(20);
  endtask

  task automatic test_backpressure();
    dec_factor = 4'd1;
    do_reset();
    m_ready = 1'b0;
    for (int v = 1; v <= 6; v++) begin
      ena  = 1'b1;
      y_in = v * 128;
      if (v <= 4) exp_q.push_back(16'(v));
      tick();
    end
    ena = 1'b0;
    tick();
    tick();
    checks++;
    if (fifo_level !== 3'd4 || ovf_flag !== 1'b1) begin
      errors++;
      $display("FAIL bp_full got l=%0d o=%b exp l=4 o=1", fifo_level, ovf_flag);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== 16'sd1) begin
        errors++;
        $display("FAIL bp_stall got v=%b d=%0d exp v=1 d=1", m_valid, m_data);
      end
      tick();
    end
    drain(20);
    checks++;
    if (fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL bp_drained got %0d exp 0", fifo_level);
    end
  endtask

  task automatic test_full_rw();
    do_reset();
    m_ready = 1'b0;
    for (int v = 11; v <= 14; v++) begin
      ena  = 1'b1;
      y_in = v * 128;
      exp_q.push_back(16'(v));
      tick();
    end
    ena = 1'b0;
    tick();
    tick();
    checks++;
    if (fifo_level !== 3'd4) begin
      errors++;
      $display("FAIL frw_pre got %0d exp 4", fifo_level);
    end
    ena  = 1'b1;
    y_in = 15 * 128;
    exp_q.push_back(16'sd15);
    tick();
    ena     = 1'b0;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++;
    if (fifo_level !== 3'd4 || ovf_flag !== 1'b0 || m_data !== 16'sd12) begin
      errors++;
      $display("FAIL frw_rw got l=%0d o=%b d=%0d exp l=4 o=0 d=12",
               fifo_level, ovf_flag, m_data);
    end
    drain(20);
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_ready = 1'b0;
    ena     = 1'b1;
    y_in    = 32'h7FFF_FFFF;
    tick();
    y_in = 22 * 128;
    tick();
    y_in = 23 * 128;
    tick();
    ena = 1'b0;
    checks++;
    if (fifo_level !== 3'd2 || sat_flag !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre got l=%0d s=%b exp l=2 s=1", fifo_level, sat_flag);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (m_valid !== 1'b0 || fifo_level !== 3'd0 || sat_flag !== 1'b0 || ovf_flag !== 1'b0) begin
      errors++;
      $display("FAIL rmid_post got v=%b l=%0d s=%b o=%b exp all 0",
               m_valid, fifo_level, sat_flag, ovf_flag);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (m_valid !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL rmid_flight got v=%b l=%0d exp v=0 l=0", m_valid, fifo_level);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    dec_factor = 4'd1;
    tick();
    tick();
    rst_n = 1'b1;
    test_reset();
    test_rounding();
    test_saturation();
    test_decimation();
    test_backpressure();
    test_full_rw();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
